spi_slave_shift: RTL and testbench
==================================

# spi_slave_shift

SPI target-side (slave) character engine: the counterpart of the SPI master shift register on the far end of the same link. Oversamples external `sclk`, `cs_n` and `mosi` in the `clk` domain, deserialises `mosi` into characters of 1..MAX_CHAR bits, and serialises buffered transmit words onto `miso`. Master and target share the same `len`/`lsb`/`rx_negedge`/`tx_negedge` encoding, so one configuration image is valid on both ends.

## Interface
- MAX_CHAR, 32, maximum character length in bits
- CHAR_LEN_BITS, 5, width of `len`; 2**CHAR_LEN_BITS == MAX_CHAR
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- len  input  CHAR_LEN_BITS  character length; 0 means MAX_CHAR, else N=len
- lsb  input  1  1: LSB first on the line
- rx_negedge  input  1  1: sample `mosi` on sclk falling edge, else rising
- tx_negedge  input  1  1: advance `miso` on sclk falling edge, else rising
- tx_data  input  MAX_CHAR  next word to send (bits [N-1:0] used)
- tx_valid  input  1  write strobe for `tx_data`
- tx_ready  output  1  1 = single-entry TX buffer empty
- rx_data  output  MAX_CHAR  last received character, right-aligned, upper bits 0
- rx_valid  output  1  `rx_data` holds an unconsumed character
- rx_ready  input  1  consumer accepts `rx_data`
- tip  output  1  character in progress
- overrun  output  1  one-cycle pulse: character completed while `rx_valid` high
- underrun  output  1  one-cycle pulse: character started with TX buffer empty
- sclk  input  1  serial clock (asynchronous)
- cs_n  input  1  chip select, active-low (asynchronous)
- mosi  input  1  serial in
- miso  output  1  serial out
- miso_oe  output  1  `miso` output enable

## Operation
- `sclk`, `cs_n`, `mosi` pass through 2-flop synchronisers; a third `sclk` flop yields `pos` (rising) and `neg` (falling) one-cycle strobes. Rx edge = `rx_negedge ? neg : pos`; tx edge = `tx_negedge ? neg : pos`.
- FSM states:
  - IDLE: `tip`=0, `miso_oe`=0. Synced `cs_n` low → START.
  - START: one cycle. Latches `len`, `lsb`, `rx_negedge`, `tx_negedge`; loads bit counter with N. Moves TX buffer to TX shift register (`tx_ready`→1); if empty, loads zeros and pulses `underrun`. → ACTIVE.
  - ACTIVE: `tip`=1, `miso_oe`=1.
- In ACTIVE:
  - `miso` presents the current TX bit: first bit is bit 0 if `lsb`, else bit N-1.
  - On each rx edge, `mosi` is written into the RX shift register at the next position (first bit → bit 0 if `lsb`, else bit N-1) and the counter decrements.
  - On a tx edge, the TX pointer advances only if at least one bit of the current character has been sampled and the counter is nonzero. This covers both clock phases.
- Counter reaches 0 after a sample (character complete):
  - If `rx_valid`=0: `rx_data` ← assembled word, `rx_valid`←1.
  - Else: the word is dropped, `rx_data` is unchanged, and `overrun` pulses.
  - Then START behaviour repeats in the same cycle (next character, fresh config latch) while `cs_n` stays low.
- Synced `cs_n` high in any state → IDLE next cycle. A partial character is discarded (no `rx_valid`, no `overrun`). The already-loaded TX word is lost. The TX buffer is untouched.
- `rx_valid` clears on `rx_valid && rx_ready`. If a new character completes in the same cycle, it is accepted without `overrun`.
- TX buffer: `tx_valid && tx_ready` writes the buffer and `tx_ready` goes 0. `tx_valid` while `tx_ready`=0 is ignored. No bypass: a write in the same cycle as an empty-buffer START causes `underrun`, and the written word is kept for the next character.
- Config inputs changing mid-character take effect at the next START.

## Timing
- Reset values: `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `tip`=0, `overrun`=0, `underrun`=0, `miso`=0, `miso_oe`=0, FSM=IDLE; synchronisers reset to `sclk`=0, `cs_n`=1, `mosi`=0.
- Pad edge to internal strobe: 3 `clk` cycles. `miso` changes 1 cycle after the tx strobe. `rx_valid` rises 1 cycle after the final rx strobe.
- `cs_n` fall to `tip`=1: 4 cycles (2 sync + START + 1).
- Requirement on the link: `sclk` high and low phases each ≥ 4 `clk` cycles; `cs_n` fall to first `sclk` edge ≥ 6 `clk` cycles.
- `rst` mid-transfer: all outputs return to reset values immediately; the TX buffer is emptied.

## Test plan
- Mode 0 (rx_negedge=0, tx_negedge=1), len=8, lsb=0, tx_data=0xA5, master sends 0x3C → `rx_data`=0x3C, `rx_valid` rises, `miso` bit sequence 1,0,1,0,0,1,0,1.
- len=0 (32 bits), lsb=1, mode 1 (rx_negedge=1, tx_negedge=0), tx_data=0x12345678, master sends 0xDEADBEEF → `rx_data`=0xDEADBEEF; `miso` LSB first equals 0x12345678.
- Two back-to-back 8-bit characters, `rx_ready` held 0 → first `rx_data` retained, one `overrun` pulse; second TX with empty buffer → `underrun` pulse and `miso`=0 for all 8 bits.
- `cs_n` raised after 5 of 8 bits → `tip`=0 within 3 cycles, no `rx_valid`, `miso_oe`=0; next full character is received correctly.
- `rst` pulsed mid-character with `tx_ready`=0 → all outputs at reset values, `tx_ready`=1.
- `tx_valid` coincident with START on an empty buffer → `underrun` pulse, and that word is sent in the following character.

Source files
------------

// File: rtl/spi_slave_shift_if.sv
// Parallel-side handshake bundle of the SPI target character engine:
// transmit buffer write port and receive data port.
interface spi_slave_shift_if #(
    parameter int MAX_CHAR = 32
) ();
    logic [MAX_CHAR-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [MAX_CHAR-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_shift.sv
// SPI target character engine: oversamples sclk/cs_n/mosi in the clk domain,
// deserialises 1..MAX_CHAR-bit characters and serialises a buffered TX word.
module spi_slave_shift #(
    parameter int MAX_CHAR      = 32,
    parameter int CHAR_LEN_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHAR_LEN_BITS-1:0] i_len,
    input  logic                     i_lsb,
    input  logic                     i_rx_negedge,
    input  logic                     i_tx_negedge,
    spi_slave_shift_if.slave         bus,
    output logic                     o_tip,
    output logic                     o_overrun,
    output logic                     o_underrun,
    input  logic                     i_sclk,
    input  logic                     i_cs_n,
    input  logic                     i_mosi,
    output logic                     o_miso,
    output logic                     o_miso_oe
);
    localparam int CW = CHAR_LEN_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_ACTIVE} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [2:0]               r_sclk_sync;
    logic [1:0]               r_cs_sync;
    logic [1:0]               r_mosi_sync;
    logic [CW-1:0]            r_n;
    logic                     r_lsb;
    logic                     r_rx_neg;
    logic                     r_tx_neg;
    logic [CW-1:0]            r_cnt;
    logic [CHAR_LEN_BITS-1:0] r_tx_idx;
    logic [CHAR_LEN_BITS-1:0] r_rx_idx;
    logic [MAX_CHAR-1:0]      r_tx_shift;
    logic [MAX_CHAR-1:0]      r_rx_shift;
    logic [MAX_CHAR-1:0]      r_buf;
    logic                     r_buf_full;
    logic [MAX_CHAR-1:0]      r_rx_data;
    logic                     r_rx_valid;
    logic                     r_overrun;
    logic                     r_underrun;

    logic                     w_pos, w_neg, w_cs_high;
    logic                     w_rx_edge, w_tx_edge;
    logic                     w_active, w_sample, w_complete, w_tx_adv, w_load;
    logic                     w_rx_accept;
    logic [CW-1:0]            w_n_new;
    logic [MAX_CHAR-1:0]      w_rx_word;

    assign w_pos       = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_neg       = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_high   = r_cs_sync[1];
    assign w_rx_edge   = r_rx_neg ? w_neg : w_pos;
    assign w_tx_edge   = r_tx_neg ? w_neg : w_pos;
    assign w_active    = (r_state == S_ACTIVE) && !w_cs_high;
    assign w_sample    = w_active && w_rx_edge;
    assign w_complete  = w_sample && (r_cnt == CW'(1));
    // TX only advances once the current character has had a bit sampled,
    // so the same rule serves both sample-first and shift-first phases.
    assign w_tx_adv    = w_active && w_tx_edge && (r_cnt != r_n) && (r_cnt != '0);
    assign w_load      = ((r_state == S_START) && !w_cs_high) || w_complete;
    assign w_rx_accept = !r_rx_valid || bus.rx_ready;
    assign w_n_new     = (i_len == '0) ? CW'(MAX_CHAR) : {1'b0, i_len};

    always_comb begin
        w_rx_word           = r_rx_shift;
        w_rx_word[r_rx_idx] = r_mosi_sync[1];
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
        end
    end

    // NOTE: next state is defaulted first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (w_cs_high) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_next = S_START;
                S_START:  w_state_next = S_ACTIVE;
                S_ACTIVE: w_state_next = S_ACTIVE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n        <= CW'(MAX_CHAR);
            r_lsb      <= 1'b0;
            r_rx_neg   <= 1'b0;
            r_tx_neg   <= 1'b0;
            r_cnt      <= '0;
            r_tx_idx   <= '0;
            r_rx_idx   <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= w_complete && !w_rx_accept;
            r_underrun <= w_load && !r_buf_full;

            if (w_sample) begin
                r_rx_shift <= w_rx_word;
                r_rx_idx   <= r_lsb ? r_rx_idx + CHAR_LEN_BITS'(1) : r_rx_idx - CHAR_LEN_BITS'(1);
                r_cnt      <= r_cnt - CW'(1);
            end
            if (w_tx_adv) begin
                r_tx_idx <= r_lsb ? r_tx_idx + CHAR_LEN_BITS'(1) : r_tx_idx - CHAR_LEN_BITS'(1);
            end

            // A load overrides the per-bit updates above on a completion cycle.
            if (w_load) begin
                r_n        <= w_n_new;
                r_lsb      <= i_lsb;
                r_rx_neg   <= i_rx_negedge;
                r_tx_neg   <= i_tx_negedge;
                r_cnt      <= w_n_new;
                r_rx_idx   <= i_lsb ? '0 : CHAR_LEN_BITS'(w_n_new - CW'(1));
                r_tx_idx   <= i_lsb ? '0 : CHAR_LEN_BITS'(w_n_new - CW'(1));
                r_rx_shift <= '0;
                r_tx_shift <= r_buf_full ? r_buf : '0;
            end

            if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (bus.tx_valid && !r_buf_full) begin
                r_buf      <= bus.tx_data;
                r_buf_full <= 1'b1;
            end

            if (w_complete && w_rx_accept) begin
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.tx_ready = ~r_buf_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign o_tip        = (r_state == S_ACTIVE);
    assign o_miso_oe    = (r_state == S_ACTIVE);
    assign o_miso       = (r_state == S_ACTIVE) && r_tx_shift[r_tx_idx];
    assign o_overrun    = r_overrun;
    assign o_underrun   = r_underrun;
endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: a behavioural SPI master drives the
// serial side while expected receive words flow through a scoreboard queue.
module tb_spi_slave_shift;
    localparam int MAX_CHAR = 32;
    localparam int H        = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  len;
    logic        lsb, rx_neg, tx_neg;
    logic        sclk, cs_n, mosi;
    logic        tip, overrun, underrun, miso, miso_oe;

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          ovr_cnt = 0;
    int          udr_cnt = 0;
    int          o0, u0;
    logic [31:0] got;
    logic [31:0] exp_q[$];

    spi_slave_shift_if #(.MAX_CHAR(MAX_CHAR)) bus ();

    spi_slave_shift #(.MAX_CHAR(MAX_CHAR), .CHAR_LEN_BITS(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_len        (len),
        .i_lsb        (lsb),
        .i_rx_negedge (rx_neg),
        .i_tx_negedge (tx_neg),
        .bus          (bus),
        .o_tip        (tip),
        .o_overrun    (overrun),
        .o_underrun   (underrun),
        .i_sclk       (sclk),
        .i_cs_n       (cs_n),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .o_miso_oe    (miso_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun === 1'b1)  ovr_cnt++;
        if (underrun === 1'b1) udr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_tx(input logic [31:0] data);
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    // Master side: mode0 drives mosi while sclk low; mode1 drives after the rise.
    task automatic send_char(input int n, input logic [31:0] word, input logic lsb_first,
                             input logic mode1, input int nbits, output logic [31:0] rx_miso);
        int p;
        rx_miso = '0;
        for (int i = 0; i < nbits; i++) begin
            p = lsb_first ? i : n - 1 - i;
            if (!mode1) begin
                mosi = word[p];
                tick(H);
                rx_miso[p] = miso;
                sclk = 1'b1;
                tick(H);
                sclk = 1'b0;
            end else begin
                sclk = 1'b1;
                mosi = word[p];
                tick(H);
                rx_miso[p] = miso;
                sclk = 1'b0;
                tick(H);
            end
        end
    endtask

    task automatic wait_rx(input string tag);
        int          k = 0;
        logic [31:0] e;
        while (bus.rx_valid !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
        check({tag, "_rx_valid"}, {31'b0, bus.rx_valid}, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check({tag, "_rx_data"}, bus.rx_data, e);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check({tag, "_rx_clear"}, {31'b0, bus.rx_valid}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        sclk         = 1'b0;
        cs_n         = 1'b1;
        mosi         = 1'b0;
        len          = 5'd8;
        lsb          = 1'b0;
        rx_neg       = 1'b0;
        tx_neg       = 1'b1;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        tick(3);
        check("rst_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
        check("rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
        check("rst_rx_data",  bus.rx_data, 32'd0);
        check("rst_tip",      {31'b0, tip}, 32'd0);
        check("rst_miso",     {31'b0, miso}, 32'd0);
        check("rst_miso_oe",  {31'b0, miso_oe}, 32'd0);
        check("rst_overrun",  {31'b0, overrun}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Mode 0, 8-bit MSB first.
        write_tx(32'hA5);
        check("m0_tx_full", {31'b0, bus.tx_ready}, 32'd0);
        u0   = udr_cnt;
        cs_n = 1'b0;
        tick(5);
        check("m0_tip",      {31'b0, tip}, 32'd1);
        check("m0_miso_oe",  {31'b0, miso_oe}, 32'd1);
        check("m0_tx_taken", {31'b0, bus.tx_ready}, 32'd1);
        check("m0_no_udr",   32'(udr_cnt - u0), 32'd0);
        exp_q.push_back(32'h3C);
        send_char(8, 32'h3C, 1'b0, 1'b0, 8, got);
        check("m0_miso_word", got, 32'hA5);
        wait_rx("m0");
        cs_n = 1'b1;
        tick(4);
        check("m0_tip_off", {31'b0, tip}, 32'd0);

        // Mode 1, 32-bit LSB first.
        len    = 5'd0;
        lsb    = 1'b1;
        rx_neg = 1'b1;
        tx_neg = 1'b0;
        write_tx(32'h12345678);
        cs_n = 1'b0;
        tick(8);
        exp_q.push_back(32'hDEADBEEF);
        send_char(32, 32'hDEADBEEF, 1'b1, 1'b1, 32, got);
        check("m1_miso_word", got, 32'h12345678);
        wait_rx("m1");
        cs_n = 1'b1;
        tick(4);

        // Back-to-back characters with rx_ready held low.
        len    = 5'd8;
        lsb    = 1'b0;
        rx_neg = 1'b0;
        tx_neg = 1'b1;
        write_tx(32'h5A);
        o0   = ovr_cnt;
        u0   = udr_cnt;
        cs_n = 1'b0;
        tick(8);
        exp_q.push_back(32'h81);
        send_char(8, 32'h81, 1'b0, 1'b0, 8, got);
        check("b2b_miso1", got, 32'h5A);
        check("b2b_udr1",  32'(udr_cnt - u0), 32'd1);
        send_char(8, 32'h7E, 1'b0, 1'b0, 8, got);
        check("b2b_miso2", got, 32'h0);
        check("b2b_ovr",   32'(ovr_cnt - o0), 32'd1);
        check("b2b_udr2",  32'(udr_cnt - u0), 32'd2);
        wait_rx("b2b");
        cs_n = 1'b1;
        tick(4);

        // Abort after 5 of 8 bits, then a clean character.
        write_tx(32'hC3);
        o0   = ovr_cnt;
        cs_n = 1'b0;
        tick(8);
        send_char(8, 32'hF0, 1'b0, 1'b0, 5, got);
        cs_n = 1'b1;
        tick(3);
        check("abort_tip",      {31'b0, tip}, 32'd0);
        check("abort_miso_oe",  {31'b0, miso_oe}, 32'd0);
        check("abort_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
        tick(2);
        check("abort_no_ovr",   32'(ovr_cnt - o0), 32'd0);
        check("abort_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
        write_tx(32'h99);
        cs_n = 1'b0;
        tick(8);
        exp_q.push_back(32'h6B);
        send_char(8, 32'h6B, 1'b0, 1'b0, 8, got);
        check("after_abort_miso", got, 32'h99);
        wait_rx("after_abort");
        cs_n = 1'b1;
        tick(4);

        // Reset in the middle of a character with the TX buffer full.
        cs_n = 1'b0;
        tick(8);
        write_tx(32'h77);
        check("rst2_tx_full", {31'b0, bus.tx_ready}, 32'd0);
        send_char(8, 32'hFF, 1'b0, 1'b0, 3, got);
        rst = 1'b1;
        tick(1);
        check("rst2_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
        check("rst2_tip",      {31'b0, tip}, 32'd0);
        check("rst2_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
        check("rst2_rx_data",  bus.rx_data, 32'd0);
        check("rst2_miso",     {31'b0, miso}, 32'd0);
        check("rst2_miso_oe",  {31'b0, miso_oe}, 32'd0);
        check("rst2_overrun",  {31'b0, overrun}, 32'd0);
        check("rst2_underrun", {31'b0, underrun}, 32'd0);
        cs_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);

        // Write landing in the same cycle as an empty-buffer START.
        u0   = udr_cnt;
        cs_n = 1'b0;
        tick(3);
        bus.tx_data  = 32'hE7;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        check("coinc_tip", {31'b0, tip}, 32'd1);
        tick(1);
        check("coinc_udr",      32'(udr_cnt - u0), 32'd1);
        check("coinc_tx_kept",  {31'b0, bus.tx_ready}, 32'd0);
        tick(5);
        exp_q.push_back(32'h11);
        send_char(8, 32'h11, 1'b0, 1'b0, 8, got);
        check("coinc_miso1", got, 32'h0);
        wait_rx("coinc1");
        exp_q.push_back(32'h22);
        send_char(8, 32'h22, 1'b0, 1'b0, 8, got);
        check("coinc_miso2", got, 32'hE7);
        wait_rx("coinc2");
        cs_n = 1'b1;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
